// File: rtl/i281_switch_conditioner_pkg.sv
// Shared constants and types for the i281 switch conditioner front end.
package i281_switch_conditioner_pkg;

  localparam int I281_SW_WIDTH          = 16;
  localparam int I281_DEF_TICK_DIV      = 50000;
  localparam int I281_DEF_STABLE_SAMPLES = 4;

  typedef enum logic {
    MODE_LIVE    = 1'b0,
    MODE_LATCHED = 1'b1
  } mode_e;

endpackage

// File: rtl/i281_debounce_bit.sv
// One-bit 2-FF synchroniser plus tick-sampled history debouncer.
module i281_debounce_bit
  import i281_switch_conditioner_pkg::*;
#(
  parameter int   STABLE_SAMPLES = I281_DEF_STABLE_SAMPLES,
  parameter logic RESET_VAL      = 1'b0
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic raw,
  input  logic tick,
  output logic level
);

  logic                      sync_p0;
  logic                      sync_p1;
  logic [STABLE_SAMPLES-1:0] hist;
  logic [STABLE_SAMPLES-1:0] hist_next;

  assign hist_next = {hist[STABLE_SAMPLES-2:0], sync_p1};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
      hist    <= {STABLE_SAMPLES{RESET_VAL}};
      level   <= RESET_VAL;
    end else begin
      // stage p0/p1: metastability chain into Clock
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // sample stage: mixed histories leave the level untouched
      if (tick) begin
        hist <= hist_next;
        if (&hist_next)
          level <= 1'b1;
        else if (~|hist_next)
          level <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i281_switch_conditioner.sv
// Conditions raw board switches and a load key into the i281_cpu Switches word,
// in either live (follow) or latched (load-on-key) mode.
module i281_switch_conditioner
  import i281_switch_conditioner_pkg::*;
#(
  parameter int WIDTH          = I281_SW_WIDTH,
  parameter int TICK_DIV       = I281_DEF_TICK_DIV,
  parameter int STABLE_SAMPLES = I281_DEF_STABLE_SAMPLES
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Sw_raw,
  input  logic             Key_raw_n,
  input  logic             Mode,
  output logic [WIDTH-1:0] Switches,
  output logic             Sw_changed,
  output logic             Key_press
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [WIDTH-1:0] db_word;
  logic             key_level;
  logic             key_level_d;
  logic             mode_p0;
  mode_e            mode_p1;
  logic             load;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + CNT_W'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_sw
    i281_debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .RESET_VAL     (1'b0)
    ) u_db (
      .Clock  (Clock),
      .Reset_n(Reset_n),
      .raw    (Sw_raw[i]),
      .tick   (tick),
      .level  (db_word[i])
    );
  end

  i281_debounce_bit #(
    .STABLE_SAMPLES(STABLE_SAMPLES),
    .RESET_VAL     (1'b1)
  ) u_key (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .raw    (Key_raw_n),
    .tick   (tick),
    .level  (key_level)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      key_level_d <= 1'b1;
      mode_p0     <= 1'b0;
      mode_p1     <= MODE_LIVE;
    end else begin
      key_level_d <= key_level;
      mode_p0     <= Mode;
      mode_p1     <= mode_e'(mode_p0);
    end
  end

  // Press is the falling edge of the debounced (active-low) key only.
  assign Key_press = key_level_d & ~key_level;
  assign load      = (mode_p1 == MODE_LIVE) || Key_press;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Switches   <= '0;
      Sw_changed <= 1'b0;
    end else if (load) begin
      // output stage: capture before any same-cycle debounce update lands
      Switches   <= db_word;
      Sw_changed <= (db_word != Switches);
    end else begin
      Sw_changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i281_switch_conditioner.sv
// Directed bench for i281_switch_conditioner with a Switches-change scoreboard.
module tb_i281_switch_conditioner;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [15:0] Sw_raw;
  logic        Key_raw_n;
  logic        Mode;
  logic [15:0] Switches;
  logic        Sw_changed;
  logic        Key_press;

  int n_checks = 0;
  int n_fail   = 0;
  int sw_pulses = 0;
  int kp_pulses = 0;
  logic [15:0] exp_q[$];

  always #5 Clock = ~Clock;

  i281_switch_conditioner #(
    .WIDTH         (16),
    .TICK_DIV      (4),
    .STABLE_SAMPLES(3)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Sw_raw    (Sw_raw),
    .Key_raw_n (Key_raw_n),
    .Mode      (Mode),
    .Switches  (Switches),
    .Sw_changed(Sw_changed),
    .Key_press (Key_press)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every Sw_changed pulse must match the next queued word.
  always @(negedge Clock) begin
    if (Key_press) kp_pulses++;
    if (Sw_changed) begin
      sw_pulses++;
      if (exp_q.size() == 0)
        chk("spurious_sw_changed", {31'd0, Sw_changed}, 32'd0);
      else
        chk("sb_switches", {16'd0, Switches}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic wait_sw(input logic [15:0] v, input int bound, output int n);
    n = 0;
    while (Switches !== v && n < bound) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge Clock);
  endtask

  initial begin
    int n;
    int p0;
    int k0;
    bit prev_kp;

    // 1: reset
    Reset_n = 1'b0; Sw_raw = 16'hFFFF; Key_raw_n = 1'b1; Mode = 1'b0;
    cycles(4);
    chk("rst_switches", {16'd0, Switches}, 32'd0);
    chk("rst_sw_changed", {31'd0, Sw_changed}, 32'd0);
    chk("rst_key_press", {31'd0, Key_press}, 32'd0);
    exp_q.push_back(16'hFFFF);
    Reset_n = 1'b1;
    wait_sw(16'hFFFF, 30, n);
    chk("rst_switches_ffff", {16'd0, Switches}, 32'h0000FFFF);
    chk("rst_latency_window", {31'd0, (n >= 12 && n <= 16)}, 32'd1);

    // 2: live mode
    Sw_raw = 16'h0000; exp_q.push_back(16'h0000);
    wait_sw(16'h0000, 30, n);
    cycles(4);
    p0 = sw_pulses;
    Sw_raw = 16'hA5C3; exp_q.push_back(16'hA5C3);
    wait_sw(16'hA5C3, 30, n);
    chk("live_switches", {16'd0, Switches}, 32'h0000A5C3);
    chk("live_latency", {31'd0, (n <= 16)}, 32'd1);
    cycles(20);
    chk("live_one_pulse", sw_pulses - p0, 32'd1);

    // 3: glitch
    Sw_raw = 16'h0000; exp_q.push_back(16'h0000);
    wait_sw(16'h0000, 30, n);
    cycles(20);
    p0 = sw_pulses;
    Sw_raw = 16'h0001;
    cycles(4);
    Sw_raw = 16'h0000;
    cycles(24);
    chk("glitch_switches", {16'd0, Switches}, 32'd0);
    chk("glitch_no_pulse", sw_pulses - p0, 32'd0);

    // 4: latched mode
    Mode = 1'b1;
    cycles(4);
    Sw_raw = 16'h1234;
    cycles(25);
    chk("latched_hold", {16'd0, Switches}, 32'd0);
    exp_q.push_back(16'h1234);
    k0 = kp_pulses;
    prev_kp = 1'b0;
    Key_raw_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (prev_kp) chk("latched_capture", {16'd0, Switches}, 32'h00001234);
      prev_kp = Key_press;
    end
    chk("key_one_press", kp_pulses - k0, 32'd1);
    Key_raw_n = 1'b1;
    cycles(30);
    chk("key_release_no_pulse", kp_pulses - k0, 32'd1);
    chk("latched_value", {16'd0, Switches}, 32'h00001234);

    // 5: reset mid-debounce
    Mode = 1'b0;
    cycles(6);
    p0 = sw_pulses;
    Sw_raw = 16'hFFFF;
    cycles(6);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_switches", {16'd0, Switches}, 32'd0);
    chk("async_rst_sw_changed", {31'd0, Sw_changed}, 32'd0);
    @(negedge Clock);
    Sw_raw = 16'h0000;
    cycles(3);
    k0 = kp_pulses;
    Reset_n = 1'b1;
    cycles(30);
    chk("post_rst_switches", {16'd0, Switches}, 32'd0);
    chk("post_rst_no_sw_pulse", sw_pulses - p0, 32'd0);
    chk("post_rst_no_key_pulse", kp_pulses - k0, 32'd0);

    // 6: mode 1->0 with pending debounced word
    Mode = 1'b1;
    cycles(4);
    Sw_raw = 16'h00FF;
    cycles(20);
    chk("mode_freeze", {16'd0, Switches}, 32'd0);
    p0 = sw_pulses;
    exp_q.push_back(16'h00FF);
    Mode = 1'b0;
    wait_sw(16'h00FF, 10, n);
    chk("mode_release_value", {16'd0, Switches}, 32'h000000FF);
    chk("mode_release_latency", {31'd0, (n <= 4)}, 32'd1);
    cycles(10);
    chk("mode_release_one_pulse", sw_pulses - p0, 32'd1);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
